// File: rtl/serial_add3_seq.sv
// Bit-serial adder of three WIDTH-bit unsigned operands, one bit slice per clock, valid/ready on both sides.
// Optional SERIAL_ADD3_OVF_EN adds an ovf output flagging a result wider than WIDTH bits.
module serial_add3_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum,
  output logic             busy
`ifdef SERIAL_ADD3_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int KW = $clog2(WIDTH + 2);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [1:0]       r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH+1:0] r_sum;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
`ifdef SERIAL_ADD3_OVF_EN
  logic             r_ovf;
`endif

  logic [2:0]       w_t;
  logic [WIDTH+1:0] w_result;

  // Operands shift right each slice, so bit 0 is always the current slice and zeros fill k >= WIDTH.
  assign w_t      = {2'b00, r_a[0]} + {2'b00, r_b[0]} + {2'b00, r_c[0]} + {1'b0, r_carry};
  assign w_result = {w_t[0], r_acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_carry     <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SERIAL_ADD3_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready re-asserts one cycle after handoff, so no accept shares the handoff cycle.
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_a        <= in1;
            r_b        <= in2;
            r_c        <= in3;
            r_carry    <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_c     <= r_c >> 1;
          r_carry <= w_t[2:1];
          r_acc   <= {w_t[0], r_acc[WIDTH:1]};
          r_k     <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_sum       <= w_result;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef SERIAL_ADD3_OVF_EN
            r_ovf       <= |w_result[WIDTH+1:WIDTH];
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
`ifdef SERIAL_ADD3_OVF_EN
            r_ovf       <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign busy      = r_busy;
`ifdef SERIAL_ADD3_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
